// File: rtl/cbx_cfg_pkg.sv
// Shared types, default geometry and local-field encoding for the
// connection-block memory-bank configuration loader.
package cbx_cfg_pkg;

  localparam int DEF_NUM_WIDE    = 9;
  localparam int DEF_BITS_WIDE   = 6;
  localparam int DEF_NUM_NARROW  = 2;
  localparam int DEF_BITS_NARROW = 2;
  localparam int DEF_TGT_AW      = 4;
  localparam int DEF_LOC_AW      = 3;

  localparam int NUM_TGT    = DEF_NUM_WIDE + DEF_NUM_NARROW;
  localparam int TOTAL_BITS = DEF_NUM_WIDE * DEF_BITS_WIDE + DEF_NUM_NARROW * DEF_BITS_NARROW;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BIT,
    SETUP,
    STROBE,
    DONE
  } state_e;

  // Wide targets use the binary local index; narrow targets place their single
  // select bit in the MSB of the local field and leave the rest zero.
  function automatic logic [7:0] encode_local(input logic narrow, input logic [7:0] idx,
                                              input int loc_aw);
    logic [7:0] r;
    if (narrow) begin
      r = '0;
      r[loc_aw-1] = idx[0];
    end else begin
      r = idx;
    end
    return r;
  endfunction

endpackage

// File: rtl/cbx_cfg_addr_seq.sv
// Target/local counters that walk every configuration bit of the connection
// block in load order and present the decoder address for the current bit.
module cbx_cfg_addr_seq
  import cbx_cfg_pkg::*;
#(
  parameter int NUM_WIDE    = DEF_NUM_WIDE,
  parameter int BITS_WIDE   = DEF_BITS_WIDE,
  parameter int NUM_NARROW  = DEF_NUM_NARROW,
  parameter int BITS_NARROW = DEF_BITS_NARROW,
  parameter int TGT_AW      = DEF_TGT_AW,
  parameter int LOC_AW      = DEF_LOC_AW
) (
  input  logic                       prog_clk,
  input  logic                       prog_reset,
  input  logic                       clear,
  input  logic                       advance,
  output logic [0:TGT_AW+LOC_AW-1]   address,
  output logic                       last
);

  localparam int N_TGT = NUM_WIDE + NUM_NARROW;

  logic [TGT_AW-1:0] tgt_q, tgt_d;
  logic [LOC_AW-1:0] loc_q, loc_d;
  logic              narrow;
  logic              loc_end;
  logic [LOC_AW-1:0] loc_field;

  always_comb begin
    narrow    = (tgt_q >= TGT_AW'(NUM_WIDE));
    loc_end   = narrow ? (loc_q == LOC_AW'(BITS_NARROW - 1))
                       : (loc_q == LOC_AW'(BITS_WIDE - 1));
    last      = (tgt_q == TGT_AW'(N_TGT - 1)) && loc_end;
    loc_field = LOC_AW'(encode_local(narrow, 8'(loc_q), LOC_AW));
    // Leftmost concat bit lands on address[0], so both fields come out MSB-first.
    address   = {loc_field, tgt_q};

    tgt_d = tgt_q;
    loc_d = loc_q;
    if (clear) begin
      tgt_d = '0;
      loc_d = '0;
    end else if (advance && !last) begin
      if (loc_end) begin
        loc_d = '0;
        tgt_d = tgt_q + 1'b1;
      end else begin
        loc_d = loc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      tgt_q <= '0;
      loc_q <= '0;
    end else begin
      tgt_q <= tgt_d;
      loc_q <= loc_d;
    end
  end

endmodule

// File: rtl/cbx_cfg_loader.sv
// Memory-bank configuration loader: takes a serial bitstream over valid/ready
// and writes each bit into the connection block with a setup-then-strobe cycle.
module cbx_cfg_loader
  import cbx_cfg_pkg::*;
#(
  parameter int NUM_WIDE    = DEF_NUM_WIDE,
  parameter int BITS_WIDE   = DEF_BITS_WIDE,
  parameter int NUM_NARROW  = DEF_NUM_NARROW,
  parameter int BITS_NARROW = DEF_BITS_NARROW,
  parameter int TGT_AW      = DEF_TGT_AW,
  parameter int LOC_AW      = DEF_LOC_AW
) (
  input  logic                      prog_clk,
  input  logic                      prog_reset,
  input  logic                      start,
  input  logic                      bs_valid,
  input  logic                      bs_data,
  output logic                      bs_ready,
  output logic [0:0]                enable,
  output logic [0:TGT_AW+LOC_AW-1]  address,
  output logic [0:0]                data_in,
  output logic                      busy,
  output logic                      done,
  output logic [5:0]                bit_count
);

  localparam int AW     = TGT_AW + LOC_AW;
  localparam int N_BITS = NUM_WIDE * BITS_WIDE + NUM_NARROW * BITS_NARROW;

  state_e          state_q, state_d;
  logic [0:AW-1]   address_q, address_d;
  logic [0:0]      data_in_q, data_in_d;
  logic [5:0]      bit_count_q, bit_count_d;
  logic [0:AW-1]   seq_address;
  logic            seq_last;
  logic            seq_clear;
  logic            seq_advance;

  cbx_cfg_addr_seq #(
    .NUM_WIDE    (NUM_WIDE),
    .BITS_WIDE   (BITS_WIDE),
    .NUM_NARROW  (NUM_NARROW),
    .BITS_NARROW (BITS_NARROW),
    .TGT_AW      (TGT_AW),
    .LOC_AW      (LOC_AW)
  ) u_addr_seq (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .clear      (seq_clear),
    .advance    (seq_advance),
    .address    (seq_address),
    .last       (seq_last)
  );

  always_comb begin
    state_d     = state_q;
    address_d   = address_q;
    data_in_d   = data_in_q;
    bit_count_d = bit_count_q;
    seq_clear   = 1'b0;
    seq_advance = 1'b0;
    bs_ready    = 1'b0;
    busy        = 1'b0;
    enable      = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          seq_clear   = 1'b1;
          bit_count_d = '0;
          state_d     = WAIT_BIT;
        end
      end
      WAIT_BIT: begin
        bs_ready = 1'b1;
        busy     = 1'b1;
        if (bs_valid) begin
          data_in_d = bs_data;
          address_d = seq_address;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        busy    = 1'b1;
        state_d = STROBE;
      end
      STROBE: begin
        // Counters advance only after the strobe so address_q stays put for it.
        busy   = 1'b1;
        enable = 1'b1;
        if (bit_count_q < 6'(N_BITS)) bit_count_d = bit_count_q + 6'd1;
        if (seq_last) begin
          state_d = DONE;
        end else begin
          seq_advance = 1'b1;
          state_d     = WAIT_BIT;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q     <= IDLE;
      address_q   <= '0;
      data_in_q   <= '0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      data_in_q   <= data_in_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign address   = address_q;
  assign data_in   = data_in_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_cbx_cfg_loader.sv
// Scenario bench for cbx_cfg_loader: accepted bits are queued with their
// expected address, and every enable strobe pops and compares one entry.
module tb_cbx_cfg_loader;

  logic        prog_clk = 1'b0;
  logic        prog_reset;
  logic        start;
  logic        bs_valid;
  logic        bs_data;
  logic        bs_ready;
  logic [0:0]  enable;
  logic [0:6]  address;
  logic [0:0]  data_in;
  logic        busy;
  logic        done;
  logic [5:0]  bit_count;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          sb_idx = 0;
  int          pulse_cnt = 0;
  int          last_en_cyc = 0;
  logic [7:0]  sb_q[$];
  logic [0:6]  pulse_addr [64];
  logic        prev_enable;
  logic [0:6]  prev_address;
  logic [0:0]  prev_data;

  cbx_cfg_loader dut (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .start      (start),
    .bs_valid   (bs_valid),
    .bs_data    (bs_data),
    .bs_ready   (bs_ready),
    .enable     (enable),
    .address    (address),
    .data_in    (data_in),
    .busy       (busy),
    .done       (done),
    .bit_count  (bit_count)
  );

  always #5 prog_clk = ~prog_clk;

  // Expected decoder address for bit i of the default 9x6 + 2x2 geometry.
  function automatic logic [0:6] exp_addr(input int i);
    logic [0:6] a;
    int t;
    int l;
    a = '0;
    if (i < 54) begin
      t = i / 6;
      l = i % 6;
      a[0:2] = 3'(l);
    end else begin
      t = 9 + (i - 54) / 2;
      l = (i - 54) % 2;
      a[0] = l[0];
    end
    a[3:6] = 4'(t);
    return a;
  endfunction

  // Observe the current cycle (scoreboard push/pop), then advance one clock.
  task automatic step();
    logic [7:0] exp;
    if (enable === 1'b1) begin
      checks++;
      if (prev_enable === 1'b1) begin
        errors++;
        $display("FAIL enable_width cyc=%0d: enable high on consecutive cycles, required single-cycle pulse", cyc);
      end
      checks++;
      if (address !== prev_address || data_in !== prev_data) begin
        errors++;
        $display("FAIL setup_hold cyc=%0d: strobe addr=%b data=%b, setup addr=%b data=%b (must match)",
                 cyc, address, data_in, prev_address, prev_data);
      end
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow cyc=%0d: strobe addr=%b with no accepted bit pending", cyc, address);
      end else begin
        exp = sb_q.pop_front();
        if ({address, data_in} !== exp) begin
          errors++;
          $display("FAIL strobe_%0d cyc=%0d: addr/data=%b, required %b", pulse_cnt, cyc,
                   {address, data_in}, exp);
        end
      end
      if (pulse_cnt < 64) pulse_addr[pulse_cnt] = address;
      pulse_cnt++;
      last_en_cyc = cyc;
    end
    if (!prog_reset && bs_valid && bs_ready) begin
      sb_q.push_back({exp_addr(sb_idx), bs_data});
      sb_idx++;
    end
    if (prog_reset) begin
      sb_q.delete();
    end else if (start && !busy && !done) begin
      sb_q.delete();
      sb_idx    = 0;
      pulse_cnt = 0;
    end
    prev_enable  = enable[0];
    prev_address = address;
    prev_data    = data_in;
    @(posedge prog_clk);
    #1;
    cyc++;
  endtask

  // Feed alternating data 1,0,1... until done or the budget runs out.
  task automatic run_until_done(input int budget, output int done_cyc, output bit timed_out);
    timed_out = 1'b1;
    done_cyc  = -1;
    for (int c = 0; c < budget; c++) begin
      if (done === 1'b1) begin
        timed_out = 1'b0;
        done_cyc  = cyc;
        break;
      end
      bs_data = (sb_idx % 2 == 0);
      step();
    end
  endtask

  task automatic begin_load(output int start_cyc);
    start_cyc = cyc;
    start     = 1'b1;
    bs_valid  = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    prog_reset = 1'b1;
    start      = 1'b0;
    bs_valid   = 1'b0;
    bs_data    = 1'b0;
    @(posedge prog_clk);
    #1;
    step();
    checks++;
    if ({enable, address, data_in, bs_ready, busy, done, bit_count} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b addr=%b din=%b rdy=%b busy=%b done=%b cnt=%0d, required all 0",
               enable, address, data_in, bs_ready, busy, done, bit_count);
    end
    prog_reset = 1'b0;
    bs_valid   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bs_ready !== 1'b0 || busy !== 1'b0 || enable !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_start[%0d]: rdy=%b busy=%b en=%b, required 0 0 0", i, bs_ready, busy, enable);
      end
      step();
    end
    bs_valid = 1'b0;
  endtask

  task automatic test_full_load();
    int s0;
    int dc;
    bit to;
    logic [0:6] want [5];
    int         idx [5];
    idx[0] = 0;  want[0] = 7'b000_0000;
    idx[1] = 6;  want[1] = 7'b000_0001;
    idx[2] = 54; want[2] = 7'b000_1001;
    idx[3] = 55; want[3] = 7'b100_1001;
    idx[4] = 57; want[4] = 7'b100_1010;
    begin_load(s0);
    run_until_done(400, dc, to);
    checks++;
    if (to || dc - s0 != 175) begin
      errors++;
      $display("FAIL full_done_cycle: done at cycle %0d (timeout=%0d), required 175", dc - s0, to);
    end
    checks++;
    if (last_en_cyc - s0 != 174) begin
      errors++;
      $display("FAIL full_last_strobe: last strobe at cycle %0d, required 174", last_en_cyc - s0);
    end
    checks++;
    if (pulse_cnt != 58) begin
      errors++;
      $display("FAIL full_pulses: %0d enable pulses, required 58", pulse_cnt);
    end
    checks++;
    if (bit_count !== 6'd58 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_done_state: bit_count=%0d busy=%b, required 58 0", bit_count, busy);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (pulse_addr[idx[k]] !== want[k]) begin
        errors++;
        $display("FAIL full_pulse_%0d_addr: %b, required %b", idx[k], pulse_addr[idx[k]], want[k]);
      end
    end
    bs_valid = 1'b0;
    step();
    step();
    checks++;
    if (bit_count !== 6'd58 || done !== 1'b0 || bs_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_idle_after: bit_count=%0d done=%b rdy=%b, required 58 0 0", bit_count, done, bs_ready);
    end
  endtask

  task automatic test_stall();
    int s0;
    int dc;
    bit to;
    begin_load(s0);
    for (int c = 0; c < 100 && sb_idx < 6; c++) begin
      bs_data = (sb_idx % 2 == 0);
      step();
    end
    bs_valid = 1'b0;
    for (int g = 0; g < 10; g++) begin
      if (g >= 2) begin
        checks++;
        if (enable !== 1'b0 || bs_ready !== 1'b1 || busy !== 1'b1 || address !== 7'b101_0000) begin
          errors++;
          $display("FAIL stall_hold[%0d]: en=%b rdy=%b busy=%b addr=%b, required 0 1 1 1010000",
                   g, enable, bs_ready, busy, address);
        end
      end
      step();
    end
    bs_valid = 1'b1;
    run_until_done(400, dc, to);
    checks++;
    if (to || pulse_cnt != 58 || pulse_addr[6] !== 7'b000_0001) begin
      errors++;
      $display("FAIL stall_resume: timeout=%0d pulses=%0d bit6 addr=%b, required 0 58 0000001",
               to, pulse_cnt, pulse_addr[6]);
    end
    step();
  endtask

  task automatic test_back_to_back_start();
    int s0;
    int dc;
    bit to;
    begin_load(s0);
    for (int c = 0; c < 200 && sb_idx < 20; c++) begin
      bs_data = (sb_idx % 2 == 0);
      step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    run_until_done(400, dc, to);
    checks++;
    if (to || dc - s0 != 175 || pulse_cnt != 58) begin
      errors++;
      $display("FAIL start_ignored: done cycle %0d pulses %0d timeout=%0d, required 175 58 0",
               dc - s0, pulse_cnt, to);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int s0;
    int dc;
    bit to;
    begin_load(s0);
    for (int c = 0; c < 200 && sb_idx < 30; c++) begin
      bs_data = (sb_idx % 2 == 0);
      step();
    end
    prog_reset = 1'b1;
    step();
    prog_reset = 1'b0;
    checks++;
    if ({enable, address, data_in, bs_ready, busy, done, bit_count} !== 17'd0) begin
      errors++;
      $display("FAIL midreset_outputs: en=%b addr=%b din=%b rdy=%b busy=%b done=%b cnt=%0d, required all 0",
               enable, address, data_in, bs_ready, busy, done, bit_count);
    end
    start      = 1'b1;
    prog_reset = 1'b1;
    step();
    prog_reset = 1'b0;
    start      = 1'b0;
    checks++;
    if (busy !== 1'b0 || bs_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start: busy=%b rdy=%b, required 0 0", busy, bs_ready);
    end
    begin_load(s0);
    checks++;
    if (bit_count !== 6'd0 || bs_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_state: bit_count=%0d rdy=%b, required 0 1", bit_count, bs_ready);
    end
    run_until_done(400, dc, to);
    checks++;
    if (to || pulse_cnt != 58 || pulse_addr[0] !== 7'b000_0000 || bit_count !== 6'd58) begin
      errors++;
      $display("FAIL restart_load: timeout=%0d pulses=%0d first addr=%b cnt=%0d, required 0 58 0000000 58",
               to, pulse_cnt, pulse_addr[0], bit_count);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_stall();
    test_back_to_back_start();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d accepted bits never strobed, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
